logistic_synth: RTL
===================

LOGISTIC_SYNTH -- requirements
Module: logistic_synth

Interface
REQ-001 SHALL have parameter N_OSC, default 4: number of square-wave voices, 1..16.
REQ-002 SHALL have parameter FRAC, default 8: fractional bits of x (0.FRAC) and r (2.FRAC), 5..12.
REQ-003 SHALL have parameter PHASE_BITS, default 12: NCO phase accumulator width.
REQ-004 SHALL have parameter PHASE_DEC, default 3: NCOs advance once every 2^PHASE_DEC clocks.
REQ-005 SHALL have parameter ITER_DIV, default 1024: clocks between iteration ticks; must be >= 2*FRAC+4.
REQ-006 SHALL have parameter R_HOLD, default 32: iterations per r step in sweep mode.
REQ-007 SHALL have parameters LO_INC, default 33, and HI_INC, default 200: NCO increments for x=0 and x->1.
REQ-008 SHALL have parameter X_SEED, default 2^(FRAC-4): initial and reseed value of x.
REQ-009 SHALL have parameter R_MIN, default 2^FRAC+2^(FRAC-4), and R_MAX, default 2^(FRAC+2)-1: sweep bounds.
REQ-010 clk  in  1  clock; all logic on rising edge.
REQ-011 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-012 mode  in  2  00 sweep, 01 hold r, 10 external r, 11 freeze (no iterations).
REQ-013 r_ext  in  FRAC+2  r value used in external mode.
REQ-014 voice_en  in  N_OSC  per-voice gate; disabled voice contributes 0 to the mix.
REQ-015 snd  out  1  PWM audio.
REQ-016 x_out  out  FRAC  current x.
REQ-017 x_valid  out  1  one-clock pulse when x_out updates.
REQ-018 r_out  out  FRAC+2  current r.
REQ-019 overrun  out  1  sticky: tick arrived while engine busy.

Function
REQ-020 Tick divider SHALL pulse once every ITER_DIV clocks, first pulse ITER_DIV clocks after reset release.
REQ-021 Engine FSM states IDLE, MUL_A, MUL_B, WRITE; IDLE->MUL_A on tick when mode!=11, else stays IDLE.
REQ-022 MUL_A: FRAC-cycle shift-add computing p = floor(x*(2^FRAC-1-x) / 2^FRAC); then MUL_B.
REQ-023 MUL_B: FRAC+2-cycle shift-add computing n = floor(r_sel*p / 2^FRAC), truncated to FRAC bits; then WRITE.
REQ-024 r_sel SHALL be latched on IDLE->MUL_A: r_ext in mode 10, else internal r.
REQ-025 WRITE (one cycle): x <= (n==0 ? X_SEED : n); x_valid high next cycle; FSM -> IDLE.
REQ-026 Tick-to-x_valid latency SHALL be exactly 2*FRAC+3 clocks.
REQ-027 Tick while FSM not IDLE SHALL be dropped and set overrun until reset.
REQ-028 Mode changes SHALL take effect at the next IDLE->MUL_A; an in-flight iteration completes unchanged.
REQ-029 Sweep: internal r increments by 1 after every R_HOLD-th WRITE; value R_MAX wraps to R_MIN; modes 01/10/11 hold internal r and its iteration count.
REQ-030 WRITE SHALL store freq[vptr] <= LO_INC + floor((HI_INC-LO_INC)*x_new / 2^FRAC); vptr round-robins 0..N_OSC-1, wrapping.
REQ-031 Each NCO: on every 2^PHASE_DEC-th clock, phase <= phase + freq[i] modulo 2^PHASE_BITS; output = phase MSB.
REQ-032 Mixer: sum = count of voices with osc[i]&voice_en[i]; K = clog2(N_OSC+1)-bit free-running counter; snd <= (counter < sum), registered.
REQ-033 All voices enabled and high SHALL give snd high 2^K-... i.e. N_OSC of every 2^K clocks; voice_en=0 SHALL give snd constantly 0.

Reset
REQ-034 While reset=0: x=X_SEED, r=R_MIN, FSM IDLE, vptr=0, all freq=LO_INC, phases 0, dividers 0, counters 0.
REQ-035 While reset=0: snd=0, x_valid=0, overrun=0, x_out=X_SEED, r_out=R_MIN.
REQ-036 Reset mid-iteration SHALL abort it with no x, freq or r update.

Structure
REQ-037 Mode encodings and FSM state encodings SHALL live in shared package logistic_pkg.
REQ-038 NCO SHALL be a sub-module logs_osc (phase accumulator + step enable), instantiated N_OSC times via generate.
REQ-039 Multipliers SHALL be a single shared shift-add datapath, not combinational multipliers.

Verification (FRAC=8, defaults)
REQ-040 Reset release, mode=01 -> first x_valid 1024+19 clocks later with x_out=0x0E, r_out=0x110.
REQ-041 mode=10, r_ext=0x000 -> n=0 each iteration, x_out reseeded to 0x10 every iteration.
REQ-042 mode=00, 33 iterations -> r_out=0x111 after the 32nd WRITE; force r=0x3FF -> wraps to 0x110 after 32 more.
REQ-043 mode=11 for 5000 clocks -> no x_valid, x_out and r_out constant, overrun=0.
REQ-044 Pulse reset=0 at MUL_B cycle 3 -> x_out=0x10, no x_valid, freq all 33 after release.
REQ-045 voice_en=4'b0000 -> snd=0 always; voice_en=4'b1111 with all osc high -> snd high 4 of every 8 clocks.

Source files
------------

// File: rtl/logistic_pkg.sv
// Shared encodings for the logistic-map synthesizer: operating modes and engine FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package logistic_pkg;

   // Operating mode as presented on the mode input.
   typedef enum logic [1:0] {
      MODE_SWEEP  = 2'b00,
      MODE_HOLD   = 2'b01,
      MODE_EXT    = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_t;

   // Iteration engine: idle, two shift-add multiply phases, one write-back cycle.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_MUL_A = 2'b01,
      ST_MUL_B = 2'b10,
      ST_WRITE = 2'b11
   } eng_state_t;

endpackage

// File: rtl/logs_osc.sv
// Square-wave NCO: phase accumulator stepped once every 2^PHASE_DEC clocks, output is the phase MSB.
// Latency: freq change affects the phase at the next step enable.
// Backpressure: none; free-running.
//
// Ports: clk, reset (sync, active-low), freq (phase increment per step), osc (square wave).
module logs_osc #(
   parameter int PHASE_BITS = 12,
   parameter int PHASE_DEC  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PHASE_BITS-1:0] freq,
   output logic                  osc
);

   localparam int DW = (PHASE_DEC > 0) ? PHASE_DEC : 1;

   logic [DW-1:0]         dec_q;
   logic [PHASE_BITS-1:0] phase_q;
   logic                  step_en;

   // With no decimation the accumulator steps on every clock.
   assign step_en = (PHASE_DEC == 0) ? 1'b1 : (dec_q == '1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         dec_q   <= '0;
         phase_q <= '0;
      end else begin
         dec_q <= dec_q + 1'b1;
         if (step_en) begin
            phase_q <= phase_q + freq;
         end
      end
   end

   assign osc = phase_q[PHASE_BITS-1];

endmodule

// File: rtl/logistic_synth.sv
// Logistic-map iterator x <= r*x*(1-x) driving a bank of square-wave NCOs mixed to a PWM output.
// Latency: iteration tick to x_valid is 2*FRAC+3 clocks; snd is one register after the voice sum.
// Backpressure: none; a tick arriving while the engine is busy is dropped and sets sticky overrun.
//
// Ports: clk, reset (sync, active-low), mode (00 sweep/01 hold/10 external r/11 freeze),
//        r_ext (external r, 2.FRAC), voice_en (per-voice gate), snd (PWM audio),
//        x_out/x_valid (current x and its update strobe), r_out (current r), overrun (sticky).
module logistic_synth
   import logistic_pkg::*;
#(
   parameter int N_OSC      = 4,
   parameter int FRAC       = 8,
   parameter int PHASE_BITS = 12,
   parameter int PHASE_DEC  = 3,
   parameter int ITER_DIV   = 1024,
   parameter int R_HOLD     = 32,
   parameter int LO_INC     = 33,
   parameter int HI_INC     = 200,
   parameter int X_SEED     = 2**(FRAC-4),
   parameter int R_MIN      = 2**FRAC + 2**(FRAC-4),
   parameter int R_MAX      = 2**(FRAC+2) - 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic [FRAC+1:0]   r_ext,
   input  logic [N_OSC-1:0]  voice_en,
   output logic              snd,
   output logic [FRAC-1:0]   x_out,
   output logic              x_valid,
   output logic [FRAC+1:0]   r_out,
   output logic              overrun
);

   localparam int AW   = 2*FRAC + 3;                   // shared product/multiplier register
   localparam int CW   = $clog2(FRAC + 3);
   localparam int DIVW = $clog2(ITER_DIV + 1);
   localparam int HW   = $clog2(R_HOLD + 1);
   localparam int VW   = (N_OSC > 1) ? $clog2(N_OSC) : 1;
   localparam int K    = $clog2(N_OSC + 1);
   localparam int PW   = PHASE_BITS + FRAC;

   localparam logic [FRAC-1:0]       X_SEED_W = FRAC'(X_SEED);
   localparam logic [FRAC+1:0]       R_MIN_W  = (FRAC+2)'(R_MIN);
   localparam logic [FRAC+1:0]       R_MAX_W  = (FRAC+2)'(R_MAX);
   localparam logic [PHASE_BITS-1:0] LO_W     = PHASE_BITS'(LO_INC);
   localparam logic [PW-1:0]         SPAN_W   = PW'(HI_INC - LO_INC);

   // ---------------------------------------------------------------- tick divider
   logic [DIVW-1:0] div_cnt;
   logic            tick;

   assign tick = (div_cnt == DIVW'(ITER_DIV - 1));

   always_ff @(posedge clk) begin
      if (!reset || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- engine FSM
   eng_state_t state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic start, step, last_a, wr, busy_tick;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (tick && (mode != MODE_FREEZE)) state_d = ST_MUL_A;
         ST_MUL_A: if (cnt_q == CW'(FRAC - 1))        state_d = ST_MUL_B;
         ST_MUL_B: if (cnt_q == CW'(FRAC + 1))        state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      start     = 1'b0;
      step      = 1'b0;
      last_a    = 1'b0;
      wr        = 1'b0;
      busy_tick = 1'b0;
      case (state_q)
         ST_IDLE:  start = tick && (mode != MODE_FREEZE);
         ST_MUL_A: begin
            step      = 1'b1;
            last_a    = (cnt_q == CW'(FRAC - 1));
            busy_tick = tick;
         end
         ST_MUL_B: begin
            step      = 1'b1;
            busy_tick = tick;
         end
         ST_WRITE: begin
            wr        = 1'b1;
            busy_tick = tick;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- shift-add datapath
   // acc holds {partial product, remaining multiplier bits}. Each step adds the
   // multiplicand into the upper part when the multiplier LSB is set, then shifts
   // right. Pass A multiplies x by ~x (= 2^FRAC-1-x) over FRAC steps, leaving
   // 4*x*~x, so p sits at bit FRAC+2. Pass B multiplies p by r over FRAC+2 steps,
   // leaving the full product from bit 0.
   logic [AW-1:0]     acc_q, acc_nxt;
   logic [FRAC+1:0]   mul_sum;
   logic [FRAC-1:0]   mcand_q;
   logic [FRAC+1:0]   r_sel_q;
   logic              sweep_q;
   logic [FRAC+1:0]   r_q;
   logic [FRAC-1:0]   x_q;

   always_comb begin
      mul_sum = {1'b0, acc_q[AW-1:FRAC+2]} + {2'b00, mcand_q & {FRAC{acc_q[0]}}};
      acc_nxt = {mul_sum, acc_q[FRAC+1:1]};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q   <= '0;
         mcand_q <= '0;
         r_sel_q <= '0;
         sweep_q <= 1'b0;
         cnt_q   <= '0;
      end else if (start) begin
         acc_q   <= {{(FRAC+3){1'b0}}, ~x_q};
         mcand_q <= x_q;
         r_sel_q <= (mode == MODE_EXT) ? r_ext : r_q;
         sweep_q <= (mode == MODE_SWEEP);
         cnt_q   <= '0;
      end else if (last_a) begin
         mcand_q <= acc_nxt[AW-2:FRAC+2];
         acc_q   <= {{(FRAC+1){1'b0}}, r_sel_q};
         cnt_q   <= '0;
      end else if (step) begin
         acc_q   <= acc_nxt;
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------- write-back
   logic [FRAC-1:0]       n_val, x_new;
   logic [PW-1:0]         scaled;
   logic [PHASE_BITS-1:0] freq_new;
   logic [PHASE_BITS-1:0] freq_q [N_OSC];
   logic [VW-1:0]         vptr;
   logic [HW-1:0]         hold_cnt;

   always_comb begin
      n_val    = acc_q[2*FRAC-1:FRAC];
      // A zero result would trap the map at 0 forever, so it reseeds instead.
      x_new    = (n_val == '0) ? X_SEED_W : n_val;
      // Constant span scaling; reduces to a fixed set of adders.
      scaled   = SPAN_W * {{PHASE_BITS{1'b0}}, x_new};
      freq_new = LO_W + PHASE_BITS'(scaled >> FRAC);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q      <= X_SEED_W;
         r_q      <= R_MIN_W;
         x_valid  <= 1'b0;
         overrun  <= 1'b0;
         vptr     <= '0;
         hold_cnt <= '0;
         for (int i = 0; i < N_OSC; i++) begin
            freq_q[i] <= LO_W;
         end
      end else begin
         x_valid <= wr;
         if (busy_tick) begin
            overrun <= 1'b1;
         end
         if (wr) begin
            x_q          <= x_new;
            freq_q[vptr] <= freq_new;
            vptr         <= (vptr == VW'(N_OSC - 1)) ? '0 : vptr + 1'b1;
            // The sweep decision uses the mode captured at iteration start.
            if (sweep_q) begin
               if (hold_cnt == HW'(R_HOLD - 1)) begin
                  hold_cnt <= '0;
                  r_q      <= (r_q == R_MAX_W) ? R_MIN_W : r_q + 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign x_out = x_q;
   assign r_out = r_q;

   // ---------------------------------------------------------------- voices and mixer
   logic [N_OSC-1:0] osc;

   for (genvar g = 0; g < N_OSC; g++) begin : g_osc
      logs_osc #(
         .PHASE_BITS (PHASE_BITS),
         .PHASE_DEC  (PHASE_DEC)
      ) u_osc (
         .clk   (clk),
         .reset (reset),
         .freq  (freq_q[g]),
         .osc   (osc[g])
      );
   end

   logic [K-1:0] voice_sum;
   logic [K-1:0] mix_cnt;

   always_comb begin
      voice_sum = '0;
      for (int i = 0; i < N_OSC; i++) begin
         voice_sum = voice_sum + K'(osc[i] & voice_en[i]);
      end
   end

   // Counter-compare PWM: snd is high for voice_sum of every 2^K clocks.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mix_cnt <= '0;
         snd     <= 1'b0;
      end else begin
         mix_cnt <= mix_cnt + 1'b1;
         snd     <= (mix_cnt < voice_sum);
      end
   end

endmodule
